// File: rtl/etroc2_frame_tx_if.sv
// Frame handshake between the upstream frame source and the ETROC2 transmitter.
interface etroc2_frame_tx_if;
    logic [39:0] din;
    logic        dinValid;
    logic        dinReady;

    modport master (output din, output dinValid, input dinReady);
    modport slave  (input din, input dinValid, output dinReady);
endinterface

// File: rtl/etroc2_frame_tx.sv
// ETROC2 frame transmitter: packs 40-bit frames MSB-first into 8/16/32-bit
// serializer words, fills gaps with idle frames, supports bit-slip and
// single-bit error injection for exercising the receiver.
module etroc2_frame_tx #(
    parameter logic [39:0] IDLE_FRAME = 40'h3C5C_A5A5_A5,
    parameter int          ACC_W      = 72
) (
    input  logic                     clk40,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               dataRate,
    etroc2_frame_tx_if.slave         s_in,
    input  logic                     slipReq,
    input  logic                     injectError,
    output logic [31:0]              dout,
    output logic [15:0]              frameCount,
    output logic [15:0]              idleCount,
    output logic                     slipPending
);

    // Accumulator is MSB-aligned: the oldest unsent bit sits at r_acc[ACC_W-1].
    logic [ACC_W-1:0] r_acc;
    logic [6:0]       r_fill;
    logic [1:0]       r_rate;
    logic             r_err;
    logic             r_slip;
    logic [31:0]      r_dout;
    logic [15:0]      r_fcnt;
    logic [15:0]      r_icnt;

    logic [1:0]       w_rate_n;
    logic             w_rate_chg;
    logic             w_active;
    logic [6:0]       w_width;
    logic             w_load;
    logic [39:0]      w_src;
    logic [39:0]      w_frame;
    logic [ACC_W-1:0] w_acc_ld;
    logic [6:0]       w_fill_ld;
    logic [31:0]      w_word;
    logic [ACC_W-1:0] w_acc_em;
    logic [6:0]       w_fill_em;
    logic             w_do_slip;
    logic [ACC_W-1:0] w_acc_nx;
    logic [6:0]       w_fill_nx;

    // Next-state datapath: optional load, emit top W bits, optional slip.
    always_comb begin
        // Rate 11 is folded onto 00 so switching between them causes no flush.
        w_rate_n   = (dataRate == 2'b11) ? 2'b00 : dataRate;
        w_rate_chg = (w_rate_n != r_rate);
        w_active   = enable & ~w_rate_chg;
        w_width    = (r_rate == 2'b01) ? 7'd16 : (r_rate == 2'b10) ? 7'd32 : 7'd8;
        w_load     = w_active & (r_fill < w_width);
        w_src      = s_in.dinValid ? s_in.din : IDLE_FRAME;
        w_frame    = w_src;
        w_frame[0] = w_src[0] ^ (r_err | injectError);
        w_acc_ld   = r_acc;
        w_fill_ld  = r_fill;
        if (w_load) begin
            w_acc_ld  = r_acc | ({w_frame, {(ACC_W-40){1'b0}}} >> r_fill);
            w_fill_ld = r_fill + 7'd40;
        end
        w_word    = w_acc_ld[ACC_W-1 -: 32] >> (7'd32 - w_width);
        w_acc_em  = w_acc_ld << w_width;
        w_fill_em = w_fill_ld - w_width;
        // A slip needs at least one bit left after the emit; otherwise wait.
        w_do_slip = w_active & r_slip & (w_fill_em != 7'd0);
        w_acc_nx  = w_do_slip ? (w_acc_em << 1) : w_acc_em;
        w_fill_nx = w_do_slip ? (w_fill_em - 7'd1) : w_fill_em;
    end

    // State update; rate change and disable both flush the accumulator.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_rate <= 2'b00;
            r_err  <= 1'b0;
            r_slip <= 1'b0;
            r_dout <= '0;
            r_fcnt <= '0;
            r_icnt <= '0;
        end else begin
            r_err  <= w_load ? 1'b0 : (r_err | injectError);
            r_slip <= w_do_slip ? 1'b0 : (r_slip | slipReq);
            if (w_rate_chg) begin
                r_rate <= w_rate_n;
                r_acc  <= '0;
                r_fill <= '0;
                r_dout <= '0;
            end else if (!enable) begin
                r_acc  <= '0;
                r_fill <= '0;
                r_dout <= '0;
            end else begin
                r_acc  <= w_acc_nx;
                r_fill <= w_fill_nx;
                r_dout <= w_word;
                if (w_load && s_in.dinValid)  r_fcnt <= r_fcnt + 16'd1;
                if (w_load && !s_in.dinValid) r_icnt <= r_icnt + 16'd1;
            end
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign s_in.dinReady = w_load & reset;
    assign dout          = r_dout;
    assign frameCount    = r_fcnt;
    assign idleCount     = r_icnt;
    assign slipPending   = r_slip;

endmodule

// File: tb/tb_etroc2_frame_tx.sv
// Self-checking bench for etroc2_frame_tx: bit-queue reference model plus
// directed literal checks and a randomized phase.
module tb_etroc2_frame_tx;
    localparam logic [39:0] IDLE = 40'h3C5C_A5A5_A5;

    logic        clk40 = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  dataRate = 2'b00;
    logic        slipReq = 1'b0;
    logic        injectError = 1'b0;
    logic [31:0] dout;
    logic [15:0] frameCount;
    logic [15:0] idleCount;
    logic        slipPending;

    etroc2_frame_tx_if ifc ();

    etroc2_frame_tx dut (
        .clk40       (clk40),
        .reset       (reset),
        .enable      (enable),
        .dataRate    (dataRate),
        .s_in        (ifc),
        .slipReq     (slipReq),
        .injectError (injectError),
        .dout        (dout),
        .frameCount  (frameCount),
        .idleCount   (idleCount),
        .slipPending (slipPending)
    );

    always #5 clk40 = ~clk40;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;
    bit list_mode = 1'b0;
    int list_idx = 0;
    logic [39:0] flist [2] = '{40'h01_2345_6789, 40'hAB_CDEF_0123};

    task automatic check(input string nm, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] norm(input logic [1:0] r);
        return (r == 2'b11) ? 2'b00 : r;
    endfunction

    function automatic int width(input logic [1:0] r);
        return (r == 2'b01) ? 16 : (r == 2'b10) ? 32 : 8;
    endfunction

    // Reference model: the transmit stream as a queue of bits.
    bit          q[$];
    logic [31:0] m_dout = '0;
    logic [15:0] m_fc = '0, m_ic = '0;
    bit          m_sp = 0, m_ep = 0;
    logic [1:0]  m_rate = 2'b00;

    always @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dout = '0; m_fc = '0; m_ic = '0; m_sp = 0; m_ep = 0; m_rate = 2'b00;
        end else if (norm(dataRate) != m_rate || !enable) begin
            m_rate = norm(dataRate);
            q.delete();
            m_dout = '0;
            m_ep = m_ep | injectError;
            m_sp = m_sp | slipReq;
        end else begin
            int w;
            logic [39:0] f;
            w = width(m_rate);
            if (q.size() < w) begin
                f = ifc.dinValid ? ifc.din : IDLE;
                if (m_ep || injectError) f[0] = ~f[0];
                m_ep = 0;
                for (int i = 39; i >= 0; i--) q.push_back(f[i]);
                if (ifc.dinValid) m_fc++; else m_ic++;
            end else begin
                m_ep = m_ep | injectError;
            end
            m_dout = '0;
            for (int i = w - 1; i >= 0; i--) m_dout[i] = q.pop_front();
            if (m_sp && q.size() > 0) begin
                void'(q.pop_front());
                m_sp = 0;
            end else begin
                m_sp = m_sp | slipReq;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk40) begin
        if (chk_en) begin
            check("dout", {8'd0, dout}, {8'd0, m_dout});
            check("frameCount", {24'd0, frameCount}, {24'd0, m_fc});
            check("idleCount", {24'd0, idleCount}, {24'd0, m_ic});
            check("slipPending", {39'd0, slipPending}, {39'd0, m_sp});
            check("dinReady", {39'd0, ifc.dinReady},
                  {39'd0, reset && enable && norm(dataRate) == m_rate && q.size() < width(m_rate)});
        end
    end

    // Advance one clock; on an accepted frame present the next one.
    task automatic cyc();
        bit fire;
        @(negedge clk40);
        fire = ifc.dinValid & ifc.dinReady;
        @(posedge clk40);
        #1;
        if (fire) begin
            if (list_mode) begin
                list_idx++;
                ifc.din = flist[list_idx % 2];
            end else begin
                ifc.din = {$urandom_range(0, 255), $urandom};
            end
        end
    endtask

    logic [7:0]  b8[];
    logic [15:0] b16[];
    logic [15:0] fc0;
    logic [39:0] d0, d1;

    initial begin
        ifc.din = 40'h0;
        ifc.dinValid = 1'b0;
        @(posedge clk40); #1;
        check("rst_dout", {8'd0, dout}, 40'd0);
        check("rst_counts", {8'd0, frameCount, idleCount}, 40'd0);
        check("rst_ready", {39'd0, ifc.dinReady}, 40'd0);
        @(posedge clk40); #1;
        reset = 1'b1;
        chk_en = 1'b1;

        // Idle stream at 8 bits.
        b8 = '{8'h3C, 8'h5C, 8'hA5, 8'hA5, 8'hA5, 8'h3C};
        foreach (b8[i]) begin
            cyc();
            check($sformatf("idle8_%0d", i), {32'd0, dout[7:0]}, {32'd0, b8[i]});
        end
        check("idle8_cnt", {8'd0, frameCount, idleCount}, {8'd0, 16'd0, 16'd2});

        // 16-bit packing of a fixed frame pair.
        enable = 1'b0; cyc();
        enable = 1'b1; dataRate = 2'b01; ifc.dinValid = 1'b1;
        list_mode = 1'b1; list_idx = 0; ifc.din = flist[0];
        check("r16_chg_rdy", {39'd0, ifc.dinReady}, 40'd0);
        cyc();
        check("r16_chg_dout", {8'd0, dout}, 40'd0);
        b16 = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0123};
        foreach (b16[i]) begin
            check($sformatf("r16_rdy_%0d", i), {39'd0, ifc.dinReady}, {39'd0, (i == 0 || i == 2)});
            cyc();
            check($sformatf("r16_dout_%0d", i), {8'd0, dout}, {24'd0, b16[i]});
        end

        // 32-bit packing of continuous random frames.
        list_mode = 1'b0;
        dataRate = 2'b10;
        ifc.din = {$urandom_range(0, 255), $urandom};
        cyc();
        check("r32_chg_dout", {8'd0, dout}, 40'd0);
        fc0 = frameCount;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("r32_rdy_%0d", i), {39'd0, ifc.dinReady}, {39'd0, (i % 5) != 4});
            if (i == 0) d0 = ifc.din;
            if (i == 1) d1 = ifc.din;
            cyc();
            if (i == 0) check("r32_w0", {8'd0, dout}, {8'd0, d0[39:8]});
            if (i == 1) check("r32_w1", {8'd0, dout}, {8'd0, d0[7:0], d1[39:16]});
            if (i == 4) check("r32_fc5", {24'd0, frameCount - fc0}, 40'd4);
        end

        // Slip at 8 bits: request while disabled, repeat request ignored.
        ifc.dinValid = 1'b0; enable = 1'b0; dataRate = 2'b00; slipReq = 1'b1;
        cyc();
        check("slip_pend", {39'd0, slipPending}, 40'd1);
        enable = 1'b1;
        cyc();
        slipReq = 1'b0;
        check("slip_clr", {39'd0, slipPending}, 40'd0);
        check("slip_b0", {32'd0, dout[7:0]}, 40'h3C);
        b8 = '{8'hB9, 8'h4B, 8'h4B, 8'h4A, 8'h78, 8'hB9};
        foreach (b8[i]) begin
            cyc();
            check($sformatf("slip_b%0d", i + 1), {32'd0, dout[7:0]}, {32'd0, b8[i]});
        end

        // Error injection on the first load after a flush.
        enable = 1'b0; cyc();
        enable = 1'b1; injectError = 1'b1;
        b8 = '{8'h3C, 8'h5C, 8'hA5, 8'hA5, 8'hA4, 8'h3C, 8'h5C, 8'hA5, 8'hA5, 8'hA5};
        foreach (b8[i]) begin
            cyc();
            injectError = 1'b0;
            check($sformatf("err_b%0d", i), {32'd0, dout[7:0]}, {32'd0, b8[i]});
        end

        // Rate switch mid-frame, then asynchronous reset mid-frame.
        cyc(); cyc();
        dataRate = 2'b10;
        cyc();
        check("sw_zero", {8'd0, dout}, 40'd0);
        cyc();
        check("sw_w0", {8'd0, dout}, 40'h3C5CA5A5);
        cyc();
        check("sw_w1", {8'd0, dout}, 40'hA53C5CA5);
        #2;
        reset = 1'b0;
        #1;
        check("arst_dout", {8'd0, dout}, 40'd0);
        check("arst_counts", {7'd0, frameCount, idleCount, slipPending}, 40'd0);
        check("arst_ready", {39'd0, ifc.dinReady}, 40'd0);
        @(posedge clk40); #1;
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            ifc.dinValid = ($urandom_range(0, 9) < 7);
            enable = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 49) == 0) dataRate = 2'($urandom_range(0, 3));
            slipReq = ($urandom_range(0, 29) == 0);
            injectError = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
